// File: rtl/portresp.sv
// -----------------------------------------------------------------------------
// portresp -- single-port word memory shared by three requesters (IC, MVU,
// Ctrl). An external arbiter raises at most one grant per cycle. Whichever
// requester is granted gets one access that cycle. A read returns its data on
// q, together with a one-cycle valid pulse on that requester's qv line.
//
// Configuration macro: PORTRESP_OREG_EN
//   undefined : read latency L = 1 (q/qv registered straight off the array)
//   defined   : read latency L = 2 (extra output register stage on q and qv)
//
// Parameters
//   a        address width; memory depth is 2**a words
//   w        data word width
//
// Ports
//   clk      in   1   sole clock, rising edge
//   rst      in   1   asynchronous, active-high reset
//   grntIC   in   1   IC requester granted this cycle
//   grntMVU  in   1   MVU requester granted this cycle
//   grntCtrl in   1   Ctrl requester granted this cycle
//   we       in   1   1 = write, 0 = read (ignored without a grant)
//   addr     in   a   word address of the granted access
//   data     in   w   write data of the granted access
//   q        out  w   read data; holds its value between responses
//   qvIC     out  1   q valid for IC (one-cycle pulse)
//   qvMVU    out  1   q valid for MVU (one-cycle pulse)
//   qvCtrl   out  1   q valid for Ctrl (one-cycle pulse)
//   errMulti out  1   sticky: more than one grant seen in a single cycle
// -----------------------------------------------------------------------------
module portresp #(
    parameter int a = 9,
    parameter int w = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         grntIC,
    input  logic         grntMVU,
    input  logic         grntCtrl,
    input  logic         we,
    input  logic [a-1:0] addr,
    input  logic [w-1:0] data,
    output logic [w-1:0] q,
    output logic         qvIC,
    output logic         qvMVU,
    output logic         qvCtrl,
    output logic         errMulti
);

    // Tag bit positions: {IC, MVU, Ctrl}, one-hot.
    localparam logic [2:0] TAG_IC   = 3'b100;
    localparam logic [2:0] TAG_MVU  = 3'b010;
    localparam logic [2:0] TAG_CTRL = 3'b001;
    localparam logic [2:0] TAG_NONE = 3'b000;

    logic [w-1:0] r_mem [0:(2**a)-1];

    logic [2:0]   w_owner;     // one-hot owner after priority resolution
    logic         w_wr_en;
    logic [2:0]   w_rd_tag;    // tag entering the pipeline (zero when idle)
    logic         w_multi;

    logic [2:0]   r_tag1;
    logic [w-1:0] r_q1;
    logic         r_err;

    // Priority IC > MVU > Ctrl picks the single owner when grants collide.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        w_owner = TAG_NONE;
        if (grntIC) begin
            w_owner = TAG_IC;
        end else if (grntMVU) begin
            w_owner = TAG_MVU;
        end else if (grntCtrl) begin
            w_owner = TAG_CTRL;
        end
    end

    assign w_wr_en  = (w_owner != TAG_NONE) && we;
    assign w_rd_tag = ((w_owner != TAG_NONE) && !we) ? w_owner : TAG_NONE;
    assign w_multi  = (grntIC & grntMVU) | (grntIC & grntCtrl) | (grntMVU & grntCtrl);

    // NOTE: the array has no reset. Its contents survive rst, and only the
    // write enable is gated so nothing is written while reset is held.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_en) begin
            r_mem[addr] <= data;
        end
    end

    // First pipeline stage: array read plus its tag. The data register only
    // loads on a read, which keeps q stable between responses.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            r_tag1 <= TAG_NONE;
            r_q1   <= '0;
            r_err  <= 1'b0;
        end else begin
            r_tag1 <= w_rd_tag;
            if (w_rd_tag != TAG_NONE) begin
                r_q1 <= r_mem[addr];
            end
            if (w_multi) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef PORTRESP_OREG_EN
    logic [2:0]   r_tag2;
    logic [w-1:0] r_q2;

    // Output register stage. Data advances only with a valid tag, so q still
    // changes only on the cycle its qv pulse is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag2 <= TAG_NONE;
            r_q2   <= '0;
        end else begin
            r_tag2 <= r_tag1;
            if (r_tag1 != TAG_NONE) begin
                r_q2 <= r_q1;
            end
        end
    end

    assign q      = r_q2;
    assign qvIC   = r_tag2[2];
    assign qvMVU  = r_tag2[1];
    assign qvCtrl = r_tag2[0];
`else
    assign q      = r_q1;
    assign qvIC   = r_tag1[2];
    assign qvMVU  = r_tag1[1];
    assign qvCtrl = r_tag1[0];
`endif

    assign errMulti = r_err;

endmodule

// File: tb/tb_portresp.sv
// -----------------------------------------------------------------------------
// tb_portresp -- self-checking bench for portresp. Stimulus tasks drive one
// access per cycle and push the expected response ({data, tag, due cycle})
// onto a scoreboard queue. They use a reference memory model for this. The
// tick task advances one clock. At the following falling edge it pops and
// compares each response that the DUT presents.
// -----------------------------------------------------------------------------
module tb_portresp;

    localparam int A = 9;
    localparam int W = 128;
`ifdef PORTRESP_OREG_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    typedef struct {
        logic [W-1:0] data;
        logic [2:0]   tag;
        int           due;
    } resp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         grntIC = 1'b0;
    logic         grntMVU = 1'b0;
    logic         grntCtrl = 1'b0;
    logic         we = 1'b0;
    logic [A-1:0] addr = '0;
    logic [W-1:0] data = '0;
    logic [W-1:0] q;
    logic         qvIC;
    logic         qvMVU;
    logic         qvCtrl;
    logic         errMulti;

    logic [W-1:0] model [0:(2**A)-1];
    resp_t        sb[$];
    logic [W-1:0] last_q = '0;
    int           cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;

    portresp #(.a(A), .w(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .grntIC   (grntIC),
        .grntMVU  (grntMVU),
        .grntCtrl (grntCtrl),
        .we       (we),
        .addr     (addr),
        .data     (data),
        .q        (q),
        .qvIC     (qvIC),
        .qvMVU    (qvMVU),
        .qvCtrl   (qvCtrl),
        .errMulti (errMulti)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock. At the falling edge, check whatever response is
    // (or should be) on the outputs.
    task automatic tick();
        logic [2:0] qv;
        resp_t      e;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        qv = {qvIC, qvMVU, qvCtrl};
        if (qv !== 3'b000) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_qv cyc=%0d qv=%b q=%h expected no response", cyc, qv, q);
            end else begin
                e = sb.pop_front();
                if (q !== e.data || qv !== e.tag || cyc != e.due) begin
                    n_fail++;
                    $display("FAIL response cyc=%0d got qv=%b q=%h expected qv=%b q=%h at cyc=%0d",
                             cyc, qv, q, e.tag, e.data, e.due);
                end
            end
            last_q = q;
        end else begin
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                n_checks++;
                n_fail++;
                e = sb.pop_front();
                $display("FAIL missing_response cyc=%0d got qv=000 expected qv=%b q=%h", cyc, e.tag, e.data);
            end
            n_checks++;
            if (q !== last_q) begin
                n_fail++;
                $display("FAIL q_hold cyc=%0d got q=%h expected q=%h", cyc, q, last_q);
            end
        end
    endtask

    // Drive one cycle's access and record its expected effect in the model.
    task automatic issue(input logic gi, input logic gm, input logic gc, input logic wr,
                         input logic [A-1:0] ad, input logic [W-1:0] d);
        logic [2:0] own;
        grntIC   = gi;
        grntMVU  = gm;
        grntCtrl = gc;
        we       = wr;
        addr     = ad;
        data     = d;
        own = gi ? 3'b100 : (gm ? 3'b010 : (gc ? 3'b001 : 3'b000));
        if (own != 3'b000) begin
            if (wr) begin
                model[ad] = d;
            end else begin
                sb.push_back('{data: model[ad], tag: own, due: cyc + L});
            end
        end
    endtask

    task automatic idle();
        grntIC   = 1'b0;
        grntMVU  = 1'b0;
        grntCtrl = 1'b0;
        we       = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && sb.size() > 0; i++) begin
            tick();
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d outstanding responses expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (q !== '0 || {qvIC, qvMVU, qvCtrl} !== 3'b000 || errMulti !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state got q=%h qv=%b err=%b expected q=0 qv=000 err=0",
                     q, {qvIC, qvMVU, qvCtrl}, errMulti);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_q = '0;
        tick();
    endtask

    // Write via Ctrl, read the same address via MVU on the very next cycle.
    task automatic test_write_read();
        issue(1'b0, 1'b0, 1'b1, 1'b1, 9'h005, {16{8'hA5}});
        tick();
        issue(1'b0, 1'b1, 1'b0, 1'b0, 9'h005, '0);
        tick();
        idle();
        repeat (L + 1) tick();
        drain();
    endtask

    // Three back-to-back reads from three different requesters.
    task automatic test_back_to_back();
        issue(1'b1, 1'b0, 1'b0, 1'b1, 9'h010, 128'd1);
        tick();
        issue(1'b0, 1'b1, 1'b0, 1'b1, 9'h011, 128'd2);
        tick();
        issue(1'b0, 1'b0, 1'b1, 1'b1, 9'h012, 128'd3);
        tick();
        issue(1'b1, 1'b0, 1'b0, 1'b0, 9'h010, '0);
        tick();
        issue(1'b0, 1'b1, 1'b0, 1'b0, 9'h011, '0);
        tick();
        issue(1'b0, 1'b0, 1'b1, 1'b0, 9'h012, '0);
        tick();
        idle();
        repeat (L + 1) tick();
        drain();
    endtask

    // Colliding grants: IC wins, and errMulti sets and sticks.
    task automatic test_multi_grant();
        issue(1'b0, 1'b0, 1'b1, 1'b1, 9'h020, 128'h1234_5678_9ABC_DEF0);
        tick();
        idle();
        tick();
        n_checks++;
        if (errMulti !== 1'b0) begin
            n_fail++;
            $display("FAIL err_before_multi got %b expected 0", errMulti);
        end
        issue(1'b1, 1'b1, 1'b0, 1'b0, 9'h020, '0);
        tick();
        idle();
        n_checks++;
        if (errMulti !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set got %b expected 1", errMulti);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (errMulti !== 1'b1) begin
                n_fail++;
                $display("FAIL err_sticky idle=%0d got %b expected 1", i, errMulti);
            end
        end
        drain();
    endtask

    // A read in flight when reset hits is discarded. A write attempted
    // while reset is held must not land.
    task automatic test_reset_in_flight();
        issue(1'b0, 1'b1, 1'b0, 1'b1, 9'h030, 128'hCAFE);
        tick();
        issue(1'b1, 1'b0, 1'b0, 1'b0, 9'h030, '0);
        tick();
        idle();
        repeat (L + 1) tick();
        drain();
        // Issue a read that is never answered; nothing goes on the scoreboard.
        grntIC = 1'b1;
        we     = 1'b0;
        addr   = 9'h030;
`ifdef PORTRESP_OREG_EN
        tick();
`endif
        rst = 1'b1;
        #1;
        last_q = '0;
        n_checks++;
        if (q !== '0 || errMulti !== 1'b0 || {qvIC, qvMVU, qvCtrl} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_async got q=%h err=%b qv=%b expected q=0 err=0 qv=000",
                     q, errMulti, {qvIC, qvMVU, qvCtrl});
        end
        grntIC   = 1'b0;
        grntCtrl = 1'b1;
        we       = 1'b1;
        addr     = 9'h030;
        data     = 128'hDEAD;
        tick();
        idle();
        tick();
        rst = 1'b0;
        repeat (4) tick();
        issue(1'b0, 1'b0, 1'b1, 1'b0, 9'h030, '0);
        tick();
        idle();
        repeat (L + 1) tick();
        drain();
    endtask

    // Top and bottom addresses hold independent data.
    task automatic test_boundary();
        issue(1'b1, 1'b0, 1'b0, 1'b1, 9'h1FF, {4{32'hFFEE_0001}});
        tick();
        issue(1'b0, 1'b1, 1'b0, 1'b1, 9'h000, {4{32'h0000_7777}});
        tick();
        issue(1'b0, 1'b0, 1'b1, 1'b0, 9'h1FF, '0);
        tick();
        issue(1'b1, 1'b0, 1'b0, 1'b0, 9'h000, '0);
        tick();
        idle();
        repeat (L + 1) tick();
        drain();
    endtask

    // Random mixed traffic over a small preloaded window, one access/cycle.
    task automatic test_mixed_stream();
        logic [A-1:0] ad;
        for (int i = 0; i < 8; i++) begin
            ad = 9'h040 + 9'(i);
            issue(1'b0, 1'b0, 1'b1, 1'b1, ad, {$urandom, $urandom, $urandom, $urandom});
            tick();
        end
        for (int i = 0; i < 40; i++) begin
            ad = 9'h040 + 9'($urandom_range(0, 7));
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0), ad, {$urandom, $urandom, $urandom, $urandom});
            tick();
        end
        idle();
        repeat (L + 1) tick();
        drain();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_multi_grant();
        test_reset_in_flight();
        test_boundary();
        test_mixed_stream();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/portresp.md
PORTRESP -- requirements
Module: portresp

Interface
REQ-001 Parameter a, default 9: address width; memory depth SHALL be 2^a words.
REQ-002 Parameter w, default 128: data word width.
REQ-003 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 grntIC  input  1  access granted to IC requester this cycle.
REQ-006 grntMVU  input  1  access granted to MVU requester this cycle.
REQ-007 grntCtrl  input  1  access granted to Ctrl requester this cycle.
REQ-008 we  input  1  1 = write access, 0 = read access; ignored when no grant is asserted.
REQ-009 addr  input  a  word address of the granted access.
REQ-010 data  input  w  write data of the granted access.
REQ-011 q  output  w  read data returned to the originating requester.
REQ-012 qvIC  output  1  q valid for IC, one-cycle pulse.
REQ-013 qvMVU  output  1  q valid for MVU, one-cycle pulse.
REQ-014 qvCtrl  output  1  q valid for Ctrl, one-cycle pulse.
REQ-015 errMulti  output  1  sticky flag: more than one grant was seen in one cycle.

Function
REQ-016 Access SHALL occur in any cycle where at least one grant is high; at most one access per cycle.
REQ-017 Write: mem[addr] SHALL take data at the rising edge; no qv pulse SHALL be generated.
REQ-018 Read: mem[addr] SHALL be returned on q with exactly one qv pulse, matching the granted requester, after latency L (L=1 base, L=2 with REQ-029).
REQ-019 A read tag (3-bit one-hot grant copy) SHALL travel in a pipeline of depth L alongside the read; qv outputs SHALL be driven from its last stage only.
REQ-020 Back-to-back reads, one per cycle, from any mix of requesters SHALL each return in order with no bubbles and no drops.
REQ-021 Read of an address written in the previous cycle SHALL return the new data; read in the same cycle as its own write is impossible (REQ-016).
REQ-022 q SHALL hold its last value while no qv is high.
REQ-023 Multiple grants in one cycle: priority IC > MVU > Ctrl SHALL select the owner; the access SHALL proceed for that owner only, and errMulti SHALL set and remain set until reset.
REQ-024 No grant: memory and the tag pipeline's new stage SHALL be idle (zero tag inserted).
REQ-025 Address arithmetic SHALL be a-bit; no wrap or bounds logic beyond the full 2^a space.

Reset
REQ-026 On rst high, immediately and independent of clk: q=0, qvIC=qvMVU=qvCtrl=0, errMulti=0, all tag stages cleared.
REQ-027 Reads in flight at reset SHALL be discarded; no qv pulse for them after rst deasserts.
REQ-028 Memory contents SHALL NOT be reset; writes SHALL be suppressed while rst is high.

Configuration
REQ-029 Macro PORTRESP_OREG_EN: when defined, an extra output register stage SHALL be inserted after the array read, making L=2 for both q and qv; when undefined, L=1. All other behaviour SHALL be identical.

Verification
REQ-030 Write addr=0x005 data=0xA5..A5 via grntCtrl, then read addr=0x005 via grntMVU next cycle -> q=0xA5..A5 with qvMVU pulse at L cycles after the read, qvIC=qvCtrl=0.
REQ-031 Reads IC@0x010, MVU@0x011, Ctrl@0x012 in three consecutive cycles (preloaded 1,2,3) -> q=1,2,3 on consecutive cycles with qvIC, qvMVU, qvCtrl pulses in that order.
REQ-032 grntIC=grntMVU=1 read addr=0x020 -> only qvIC pulses; errMulti=1 from next edge and stays 1 across 10 idle cycles.
REQ-033 Read issued, rst asserted the cycle after, deasserted 2 cycles later -> no qv pulse at any time; q=0, errMulti=0 immediately on rst.
REQ-034 Write addr=0x1FF then addr=0x000 with distinct data; read both -> each returns its own data (top-address boundary, no aliasing).
REQ-035 Run REQ-030 and REQ-031 with and without PORTRESP_OREG_EN -> identical data/order, response offset 1 vs 2 cycles.
